des_round_engine: RTL and testbench
===================================

Name: des_round_engine

Overview:
- Iterative DES cipher core for the IoT data-filtering datapath. Encrypts or decrypts one 64-bit block against a 64-bit key.
- Executes one Feistel round per clock: expansion E, subkey XOR, S-box substitution, P permutation.
- Sits directly upstream of, and instantiates, the team's eight S-box modules S1_BOX..S8_BOX (6-bit din, 4-bit dout; row = {din[5],din[0]}, col = din[4:1]).
- Upstream: the filter controller issues blocks over a valid/ready handshake. Downstream: results are consumed over the same handshake.

Parameters:
- NUM_ROUNDS, 16, rounds per block. Only 16 is a supported value; it sizes the round counter.

Ports:
- i_clk  input  1  clock, rising edge.
- i_rst_n  input  1  reset, asynchronous, active-low.
- i_in_valid  input  1  block request valid.
- o_in_ready  output  1  engine can accept a block.
- i_mode  input  1  0 = encrypt, 1 = decrypt. Sampled on accept.
- i_data  input  64  plaintext or ciphertext, bit 63 = DES bit 1. Sampled on accept.
- i_key  input  64  key including parity bits; parity is ignored. Sampled on accept.
- o_out_valid  output  1  result valid.
- i_out_ready  input  1  consumer accepts the result.
- o_data  output  64  result block.

Behaviour:
- Reset (asynchronous assert, synchronous release):
  - state = IDLE, round counter = 0, L/R/C/D registers = 0.
  - o_in_ready = 1, o_out_valid = 0, o_data = 0.
- States: IDLE, ROUND, DONE.
- IDLE:
  - o_in_ready = 1.
  - Accept occurs when i_in_valid & o_in_ready at a rising edge.
  - On accept: L,R <= IP(i_data); C,D <= PC1(i_key); mode latched; counter <= 0; go to ROUND.
- ROUND: one round per edge, with o_in_ready = 0.
  - Encrypt subkey schedule: rotate C and D left by 1 in rounds 1, 2, 9, 16 and by 2 otherwise, then K = PC2(C,D).
  - Decrypt subkey schedule: rotate right by 0 in round 1, by 1 in rounds 2, 9, 16, by 2 otherwise.
  - Each round: L' = R; R' = L ^ P(S(E(R) ^ K)).
  - S-box input slicing: S1 takes bits 47:42 of E(R)^K, …, S8 takes bits 5:0. The outputs are concatenated S1..S8, MSB first.
  - On the edge that completes round NUM_ROUNDS: o_data <= FP({R16,L16}) (the swap is undone before FP); o_out_valid <= 1; go to DONE.
- Latency: accept edge E0, round edges E1..E16. o_out_valid is high after E16, i.e. 16 cycles after acceptance.
- DONE:
  - o_data and o_out_valid hold stable until i_out_ready is sampled high.
  - On that edge: o_out_valid <= 0; go to IDLE. o_data retains its value but is don't-care.
  - o_in_ready = 0 in DONE. No bypass: the next accept is at the earliest the edge after the return to IDLE.
  - Sustained throughput is therefore 1 block per 18 cycles.
- Input handling:
  - i_in_valid while busy is ignored. The upstream must hold it until o_in_ready.
  - i_data, i_key and i_mode changes after accept have no effect.
- i_out_ready while not in DONE is ignored.
- Reset asserted mid-ROUND or mid-DONE aborts the block immediately. There is no partial output, and o_out_valid drops asynchronously.
- All permutation tables (IP, FP, E, P, PC1, PC2) follow FIPS 46-3 with bit 1 = MSB.
- All arithmetic is bitwise XOR and fixed-width rotation on 28-bit C/D halves; no carries.

Test Plan:
- Encrypt: key 133457799BBCDFF1, data 0123456789ABCDEF, mode 0 → o_data 85E813540F0AB405, with o_out_valid rising exactly 16 cycles after accept.
- Decrypt: key 133457799BBCDFF1, data 85E813540F0AB405, mode 1 → o_data 0123456789ABCDEF.
- Zero vector: key 0000000000000000, data 0000000000000000, mode 0 → 8CA64DE9C1B123A7. Also key 0101010101010101 (parity bits only set) → same result, since parity is ignored.
- Backpressure: hold i_out_ready = 0 for 10 cycles after o_out_valid, toggling i_in_valid and i_data meanwhile → o_data is stable, o_in_ready stays 0, and no new block is accepted. Then raise i_out_ready for 1 cycle → o_out_valid falls and o_in_ready returns 1 on the next cycle.
- Back-to-back: two blocks with i_in_valid held high → accepts spaced 18 cycles apart, both results correct and in order.
- Reset abort: assert i_rst_n = 0 at round 7 for 1 cycle → o_out_valid stays 0, o_in_ready = 1. A subsequent block produces the correct result.

Source files
------------

// File: rtl/des_round_engine.sv
// des_round_engine: iterative DES cipher core, one Feistel round per clock.
// A 64-bit block is accepted over a valid/ready handshake together with a key
// and a mode bit. Sixteen rounds later the result is held on o_data until the
// consumer takes it. The eight S-box lookups are small standalone modules.
//
// Ports:
//   i_clk        clock, rising edge
//   i_rst_n      asynchronous active-low reset (synchronous release)
//   i_in_valid   block request valid
//   o_in_ready   engine idle and able to accept a block
//   i_mode       0 = encrypt, 1 = decrypt (sampled on accept)
//   i_data       64-bit input block, bit 63 = DES bit 1 (sampled on accept)
//   i_key        64-bit key incl. parity bits (sampled on accept)
//   o_out_valid  result valid, held until i_out_ready
//   i_out_ready  consumer accepts the result
//   o_data       64-bit result block

module S1_BOX (
    input  logic [5:0] din,
    output logic [3:0] dout
);
    localparam logic [255:0] TBL = 256'hE4D12FB83A6C5907_0F74E2D1A6CB9538_41E8D62BFC973A50_FC8249175B3EA06D;
    // Entry (row*16 + col) sits at nibble 63-index counted from the LSB.
    assign dout = TBL[{~{din[5], din[0], din[4:1]}, 2'b00} +: 4];
endmodule

module S2_BOX (
    input  logic [5:0] din,
    output logic [3:0] dout
);
    localparam logic [255:0] TBL = 256'hF18E6B34972DC05A_3D47F28EC01A69B5_0E7BA4D158C6932F_D8A13F42B67C05E9;
    assign dout = TBL[{~{din[5], din[0], din[4:1]}, 2'b00} +: 4];
endmodule

module S3_BOX (
    input  logic [5:0] din,
    output logic [3:0] dout
);
    localparam logic [255:0] TBL = 256'hA09E63F51DC7B428_D709346A285ECBF1_D6498F30B12C5AE7_1AD069874FE3B52C;
    assign dout = TBL[{~{din[5], din[0], din[4:1]}, 2'b00} +: 4];
endmodule

module S4_BOX (
    input  logic [5:0] din,
    output logic [3:0] dout
);
    localparam logic [255:0] TBL = 256'h7DE3069A1285BC4F_D8B56F03472C1AE9_A690CB7DF13E5284_3F06A1D8945BC72E;
    assign dout = TBL[{~{din[5], din[0], din[4:1]}, 2'b00} +: 4];
endmodule

module S5_BOX (
    input  logic [5:0] din,
    output logic [3:0] dout
);
    localparam logic [255:0] TBL = 256'h2C417AB6853FD0E9_EB2C47D150FA3986_421BAD78F9C5630E_B8C71E2D6F09A453;
    assign dout = TBL[{~{din[5], din[0], din[4:1]}, 2'b00} +: 4];
endmodule

module S6_BOX (
    input  logic [5:0] din,
    output logic [3:0] dout
);
    localparam logic [255:0] TBL = 256'hC1AF92680D34E75B_AF427C9561DE0B38_9EF528C3704A1DB6_432C95FABE17608D;
    assign dout = TBL[{~{din[5], din[0], din[4:1]}, 2'b00} +: 4];
endmodule

module S7_BOX (
    input  logic [5:0] din,
    output logic [3:0] dout
);
    localparam logic [255:0] TBL = 256'h4B2EF08D3C975A61_D0B7491AE35C2F86_14BDC37EAF680592_6BD814A7950FE23C;
    assign dout = TBL[{~{din[5], din[0], din[4:1]}, 2'b00} +: 4];
endmodule

module S8_BOX (
    input  logic [5:0] din,
    output logic [3:0] dout
);
    localparam logic [255:0] TBL = 256'hD2846FB1A93E50C7_1FD8A374C56B0E92_7B419CE206ADF358_21E74A8DFC90356B;
    assign dout = TBL[{~{din[5], din[0], din[4:1]}, 2'b00} +: 4];
endmodule

module des_round_engine #(
    parameter int NUM_ROUNDS = 16
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_in_valid,
    output logic        o_in_ready,
    input  logic        i_mode,
    input  logic [63:0] i_data,
    input  logic [63:0] i_key,
    output logic        o_out_valid,
    input  logic        i_out_ready,
    output logic [63:0] o_data
);
    localparam int CNT_W = $clog2(NUM_ROUNDS);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(NUM_ROUNDS - 1);

    // Permutation tables: entry i names the source bit (1 = MSB) of output bit i+1.
    localparam int IP_T [64] = '{
        58, 50, 42, 34, 26, 18, 10, 2, 60, 52, 44, 36, 28, 20, 12, 4,
        62, 54, 46, 38, 30, 22, 14, 6, 64, 56, 48, 40, 32, 24, 16, 8,
        57, 49, 41, 33, 25, 17,  9, 1, 59, 51, 43, 35, 27, 19, 11, 3,
        61, 53, 45, 37, 29, 21, 13, 5, 63, 55, 47, 39, 31, 23, 15, 7};
    localparam int FP_T [64] = '{
        40, 8, 48, 16, 56, 24, 64, 32, 39, 7, 47, 15, 55, 23, 63, 31,
        38, 6, 46, 14, 54, 22, 62, 30, 37, 5, 45, 13, 53, 21, 61, 29,
        36, 4, 44, 12, 52, 20, 60, 28, 35, 3, 43, 11, 51, 19, 59, 27,
        34, 2, 42, 10, 50, 18, 58, 26, 33, 1, 41,  9, 49, 17, 57, 25};
    localparam int E_T [48] = '{
        32,  1,  2,  3,  4,  5,  4,  5,  6,  7,  8,  9,
         8,  9, 10, 11, 12, 13, 12, 13, 14, 15, 16, 17,
        16, 17, 18, 19, 20, 21, 20, 21, 22, 23, 24, 25,
        24, 25, 26, 27, 28, 29, 28, 29, 30, 31, 32,  1};
    localparam int P_T [32] = '{
        16,  7, 20, 21, 29, 12, 28, 17,  1, 15, 23, 26,  5, 18, 31, 10,
         2,  8, 24, 14, 32, 27,  3,  9, 19, 13, 30,  6, 22, 11,  4, 25};
    localparam int PC1_T [56] = '{
        57, 49, 41, 33, 25, 17,  9,  1, 58, 50, 42, 34, 26, 18,
        10,  2, 59, 51, 43, 35, 27, 19, 11,  3, 60, 52, 44, 36,
        63, 55, 47, 39, 31, 23, 15,  7, 62, 54, 46, 38, 30, 22,
        14,  6, 61, 53, 45, 37, 29, 21, 13,  5, 28, 20, 12,  4};
    localparam int PC2_T [48] = '{
        14, 17, 11, 24,  1,  5,  3, 28, 15,  6, 21, 10,
        23, 19, 12,  4, 26,  8, 16,  7, 27, 20, 13,  2,
        41, 52, 31, 37, 47, 55, 30, 40, 51, 45, 33, 48,
        44, 49, 39, 56, 34, 53, 46, 42, 50, 36, 29, 32};

    function automatic logic [63:0] perm_ip(input logic [63:0] x);
        logic [63:0] y;
        y = '0;
        for (int i = 0; i < 64; i++) y[6'(63 - i)] = x[6'(64 - IP_T[6'(i)])];
        return y;
    endfunction

    function automatic logic [63:0] perm_fp(input logic [63:0] x);
        logic [63:0] y;
        y = '0;
        for (int i = 0; i < 64; i++) y[6'(63 - i)] = x[6'(64 - FP_T[6'(i)])];
        return y;
    endfunction

    function automatic logic [47:0] perm_e(input logic [31:0] x);
        logic [47:0] y;
        y = '0;
        for (int i = 0; i < 48; i++) y[6'(47 - i)] = x[5'(32 - E_T[6'(i)])];
        return y;
    endfunction

    function automatic logic [31:0] perm_p(input logic [31:0] x);
        logic [31:0] y;
        y = '0;
        for (int i = 0; i < 32; i++) y[5'(31 - i)] = x[5'(32 - P_T[5'(i)])];
        return y;
    endfunction

    function automatic logic [55:0] perm_pc1(input logic [63:0] x);
        logic [55:0] y;
        y = '0;
        for (int i = 0; i < 56; i++) y[6'(55 - i)] = x[6'(64 - PC1_T[6'(i)])];
        return y;
    endfunction

    function automatic logic [47:0] perm_pc2(input logic [55:0] x);
        logic [47:0] y;
        y = '0;
        for (int i = 0; i < 48; i++) y[6'(47 - i)] = x[6'(56 - PC2_T[6'(i)])];
        return y;
    endfunction

    function automatic logic [27:0] rotl28(input logic [27:0] x, input logic two);
        return two ? {x[25:0], x[27:26]} : {x[26:0], x[27]};
    endfunction

    function automatic logic [27:0] rotr28(input logic [27:0] x, input logic two);
        return two ? {x[1:0], x[27:2]} : {x[0], x[27:1]};
    endfunction

    typedef enum logic [1:0] {ST_IDLE, ST_ROUND, ST_DONE} state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [31:0]      l_q, l_d, r_q, r_d;
    logic [27:0]      c_q, c_d, d_q, d_d;
    logic             mode_q, mode_d;
    logic             out_valid_q, out_valid_d;
    logic [63:0]      data_q, data_d;

    logic        one_step;
    logic [27:0] c_rot, d_rot;
    logic [47:0] subkey, sb_in;
    logic [31:0] sb_out, r_new;

    // cnt_q holds (round number - 1); rounds 1, 2, 9 and 16 use single-bit steps.
    assign one_step = (cnt_q == CNT_W'(0)) || (cnt_q == CNT_W'(1)) ||
                      (cnt_q == CNT_W'(8)) || (cnt_q == LAST_CNT);

    // Decrypt walks the encrypt schedule backwards: round 1 reuses the
    // fully-rotated C/D (equal to PC1 output), later rounds undo one step each.
    always_comb begin
        c_rot = c_q;
        d_rot = d_q;
        if (!mode_q) begin
            c_rot = rotl28(c_q, !one_step);
            d_rot = rotl28(d_q, !one_step);
        end else if (cnt_q != CNT_W'(0)) begin
            c_rot = rotr28(c_q, !one_step);
            d_rot = rotr28(d_q, !one_step);
        end
    end

    assign subkey = perm_pc2({c_rot, d_rot});
    assign sb_in  = perm_e(r_q) ^ subkey;

    S1_BOX u_s1 (.din(sb_in[47:42]), .dout(sb_out[31:28]));
    S2_BOX u_s2 (.din(sb_in[41:36]), .dout(sb_out[27:24]));
    S3_BOX u_s3 (.din(sb_in[35:30]), .dout(sb_out[23:20]));
    S4_BOX u_s4 (.din(sb_in[29:24]), .dout(sb_out[19:16]));
    S5_BOX u_s5 (.din(sb_in[23:18]), .dout(sb_out[15:12]));
    S6_BOX u_s6 (.din(sb_in[17:12]), .dout(sb_out[11:8]));
    S7_BOX u_s7 (.din(sb_in[11:6]),  .dout(sb_out[7:4]));
    S8_BOX u_s8 (.din(sb_in[5:0]),   .dout(sb_out[3:0]));

    assign r_new = l_q ^ perm_p(sb_out);

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        l_d         = l_q;
        r_d         = r_q;
        c_d         = c_q;
        d_d         = d_q;
        mode_d      = mode_q;
        out_valid_d = out_valid_q;
        data_d      = data_q;
        unique case (state_q)
            ST_IDLE: begin
                if (i_in_valid) begin
                    {l_d, r_d} = perm_ip(i_data);
                    {c_d, d_d} = perm_pc1(i_key);
                    mode_d     = i_mode;
                    cnt_d      = '0;
                    state_d    = ST_ROUND;
                end
            end
            ST_ROUND: begin
                l_d   = r_q;
                r_d   = r_new;
                c_d   = c_rot;
                d_d   = d_rot;
                cnt_d = cnt_q + CNT_W'(1);
                if (cnt_q == LAST_CNT) begin
                    // Final swap undone: FP sees {R16, L16}.
                    data_d      = perm_fp({r_new, r_q});
                    out_valid_d = 1'b1;
                    state_d     = ST_DONE;
                end
            end
            ST_DONE: begin
                if (i_out_ready) begin
                    out_valid_d = 1'b0;
                    state_d     = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            l_q         <= '0;
            r_q         <= '0;
            c_q         <= '0;
            d_q         <= '0;
            mode_q      <= 1'b0;
            out_valid_q <= 1'b0;
            data_q      <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            l_q         <= l_d;
            r_q         <= r_d;
            c_q         <= c_d;
            d_q         <= d_d;
            mode_q      <= mode_d;
            out_valid_q <= out_valid_d;
            data_q      <= data_d;
        end
    end

    assign o_in_ready  = (state_q == ST_IDLE);
    assign o_out_valid = out_valid_q;
    assign o_data      = data_q;

endmodule

// File: tb/tb_des_round_engine.sv
// tb_des_round_engine: directed bench for des_round_engine. A behavioural DES
// model (precomputed subkey list, reversed for decrypt) predicts every result;
// a negedge monitor compares outputs, ready, and latency against it.

module tb_des_round_engine;
    logic        clk = 1'b0;
    logic        i_rst_n, i_in_valid, i_mode, i_out_ready;
    logic [63:0] i_data, i_key;
    logic        o_in_ready, o_out_valid;
    logic [63:0] o_data;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    localparam logic [63:0] K1 = 64'h133457799BBCDFF1;
    localparam logic [63:0] P1 = 64'h0123456789ABCDEF;
    localparam logic [63:0] C1 = 64'h85E813540F0AB405;
    localparam logic [63:0] KP = 64'h0101010101010101;
    localparam logic [63:0] Z1 = 64'h8CA64DE9C1B123A7;

    always #5 clk = ~clk;

    des_round_engine #(.NUM_ROUNDS(16)) dut (
        .i_clk(clk), .i_rst_n(i_rst_n), .i_in_valid(i_in_valid), .o_in_ready(o_in_ready),
        .i_mode(i_mode), .i_data(i_data), .i_key(i_key), .o_out_valid(o_out_valid),
        .i_out_ready(i_out_ready), .o_data(o_data));

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    int IP_T[$]  = '{58,50,42,34,26,18,10,2,60,52,44,36,28,20,12,4,62,54,46,38,30,22,14,6,
                     64,56,48,40,32,24,16,8,57,49,41,33,25,17,9,1,59,51,43,35,27,19,11,3,
                     61,53,45,37,29,21,13,5,63,55,47,39,31,23,15,7};
    int FP_T[$]  = '{40,8,48,16,56,24,64,32,39,7,47,15,55,23,63,31,38,6,46,14,54,22,62,30,
                     37,5,45,13,53,21,61,29,36,4,44,12,52,20,60,28,35,3,43,11,51,19,59,27,
                     34,2,42,10,50,18,58,26,33,1,41,9,49,17,57,25};
    int E_T[$]   = '{32,1,2,3,4,5,4,5,6,7,8,9,8,9,10,11,12,13,12,13,14,15,16,17,
                     16,17,18,19,20,21,20,21,22,23,24,25,24,25,26,27,28,29,28,29,30,31,32,1};
    int P_T[$]   = '{16,7,20,21,29,12,28,17,1,15,23,26,5,18,31,10,
                     2,8,24,14,32,27,3,9,19,13,30,6,22,11,4,25};
    int PC1_T[$] = '{57,49,41,33,25,17,9,1,58,50,42,34,26,18,10,2,59,51,43,35,27,19,11,3,
                     60,52,44,36,63,55,47,39,31,23,15,7,62,54,46,38,30,22,14,6,61,53,45,37,
                     29,21,13,5,28,20,12,4};
    int PC2_T[$] = '{14,17,11,24,1,5,3,28,15,6,21,10,23,19,12,4,26,8,16,7,27,20,13,2,
                     41,52,31,37,47,55,30,40,51,45,33,48,44,49,39,56,34,53,46,42,50,36,29,32};
    int SHIFTS[$] = '{1,1,2,2,2,2,2,2,1,2,2,2,2,2,2,1};
    logic [255:0] SBX [8] = '{
        256'hE4D12FB83A6C5907_0F74E2D1A6CB9538_41E8D62BFC973A50_FC8249175B3EA06D,
        256'hF18E6B34972DC05A_3D47F28EC01A69B5_0E7BA4D158C6932F_D8A13F42B67C05E9,
        256'hA09E63F51DC7B428_D709346A285ECBF1_D6498F30B12C5AE7_1AD069874FE3B52C,
        256'h7DE3069A1285BC4F_D8B56F03472C1AE9_A690CB7DF13E5284_3F06A1D8945BC72E,
        256'h2C417AB6853FD0E9_EB2C47D150FA3986_421BAD78F9C5630E_B8C71E2D6F09A453,
        256'hC1AF92680D34E75B_AF427C9561DE0B38_9EF528C3704A1DB6_432C95FABE17608D,
        256'h4B2EF08D3C975A61_D0B7491AE35C2F86_14BDC37EAF680592_6BD814A7950FE23C,
        256'hD2846FB1A93E50C7_1FD8A374C56B0E92_7B419CE206ADF358_21E74A8DFC90356B};

    // Output bit j (1 = MSB of an n-bit result) takes source bit t[j-1] of a src_w-bit word.
    function automatic logic [63:0] permute(input logic [63:0] src, input int src_w, input int t[$]);
        logic [63:0] res;
        int n;
        res = '0;
        n = t.size();
        for (int j = 0; j < n; j++)
            if (((src >> (src_w - t[j])) & 64'd1) != 64'd0) res = res | (64'd1 << (n - 1 - j));
        return res;
    endfunction

    function automatic logic [31:0] feistel(input logic [31:0] r, input logic [47:0] k);
        logic [47:0] x;
        logic [31:0] s;
        logic [5:0]  six;
        int idx;
        x = 48'(permute({32'h0, r}, 32, E_T)) ^ k;
        s = '0;
        for (int b = 0; b < 8; b++) begin
            six = 6'(x >> (42 - 6 * b));
            idx = {26'd0, six[5], six[0], six[4:1]};
            s = {s[27:0], 4'(SBX[b] >> (4 * (63 - idx)))};
        end
        return 32'(permute({32'h0, s}, 32, P_T));
    endfunction

    function automatic logic [63:0] des_model(input logic [63:0] key, input logic [63:0] data, input logic dec);
        logic [55:0] cd;
        logic [27:0] c, d;
        logic [47:0] ks [16];
        logic [63:0] ip;
        logic [31:0] l, r, tmp;
        cd = 56'(permute(key, 64, PC1_T));
        c = cd[55:28];
        d = cd[27:0];
        for (int i = 0; i < 16; i++) begin
            for (int s = 0; s < SHIFTS[i]; s++) begin
                c = {c[26:0], c[27]};
                d = {d[26:0], d[27]};
            end
            ks[i] = 48'(permute({8'h0, c, d}, 56, PC2_T));
        end
        ip = permute(data, 64, IP_T);
        l = ip[63:32];
        r = ip[31:0];
        for (int i = 0; i < 16; i++) begin
            tmp = r;
            r = l ^ feistel(r, dec ? ks[15 - i] : ks[i]);
            l = tmp;
        end
        return permute({r, l}, 64, FP_T);
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Monitor: model of accepts, expected results, ready and latency.
    logic [63:0] exp_q[$];
    int          acc_q[$];
    bit          busy = 0;
    bit          prev_valid = 0;

    initial forever begin
        @(negedge clk);
        if (!i_rst_n) begin
            exp_q.delete();
            acc_q.delete();
            busy = 0;
            prev_valid = 0;
            chk("reset_out_valid", 64'(o_out_valid), 64'd0);
            chk("reset_in_ready", 64'(o_in_ready), 64'd1);
            chk("reset_o_data", o_data, 64'd0);
        end else begin
            chk("in_ready", 64'(o_in_ready), 64'(!busy));
            if (i_in_valid && !busy) begin
                exp_q.push_back(des_model(i_key, i_data, i_mode));
                acc_q.push_back(cyc + 1);
                busy = 1;
            end
            if (o_out_valid) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL spurious_valid: o_out_valid=1 with no block pending, o_data=%h", o_data);
                end else begin
                    chk("o_data_model", o_data, exp_q[0]);
                    if (!prev_valid) chk("latency", 64'(cyc - acc_q[0]), 64'd16);
                    if (i_out_ready) begin
                        void'(exp_q.pop_front());
                        void'(acc_q.pop_front());
                        busy = 0;
                    end
                end
            end
            prev_valid = o_out_valid;
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_valid(input string nm, output bit ok);
        ok = 0;
        for (int n = 0; n < 40 && !ok; n++) begin
            @(negedge clk);
            if (o_out_valid) ok = 1;
        end
        if (!ok) begin
            checks++;
            errors++;
            $display("FAIL %s_timeout: o_out_valid=0, expected 1 within 40 cycles", nm);
        end
    endtask

    // Starts at posedge+1 with the engine idle; ends at posedge+1 after the handshake.
    task automatic run_block(input logic [63:0] key, input logic [63:0] data, input logic mode,
                             input logic [63:0] lit, input string nm);
        bit ok;
        i_key = key;
        i_data = data;
        i_mode = mode;
        i_in_valid = 1;
        tick();
        i_in_valid = 0;
        i_data = {$urandom, $urandom};
        i_key = {$urandom, $urandom};
        i_mode = ~mode;
        wait_valid(nm, ok);
        if (ok) chk(nm, o_data, lit);
        tick();
    endtask

    initial begin
        bit ok, seen;
        int acc1, acc2;
        i_rst_n = 0;
        i_in_valid = 0;
        i_mode = 0;
        i_out_ready = 1;
        i_data = '0;
        i_key = '0;
        repeat (3) tick();
        i_rst_n = 1;

        chk("model_encrypt", des_model(K1, P1, 1'b0), C1);
        chk("model_decrypt", des_model(K1, C1, 1'b1), P1);
        chk("model_zero", des_model(64'd0, 64'd0, 1'b0), Z1);
        chk("model_parity_key", des_model(KP, 64'd0, 1'b0), Z1);

        tick();
        run_block(K1, P1, 1'b0, C1, "encrypt");
        run_block(K1, C1, 1'b1, P1, "decrypt");
        run_block(64'd0, 64'd0, 1'b0, Z1, "zero_vector");
        run_block(KP, 64'd0, 1'b0, Z1, "parity_key");

        // Backpressure: result must hold while the consumer stalls.
        i_out_ready = 0;
        i_key = K1;
        i_data = P1;
        i_mode = 0;
        i_in_valid = 1;
        tick();
        i_in_valid = 0;
        wait_valid("bp", ok);
        if (ok) chk("bp_first", o_data, C1);
        for (int k = 0; k < 10; k++) begin
            tick();
            i_in_valid = ~i_in_valid;
            i_data = {$urandom, $urandom};
            @(negedge clk);
            chk("bp_hold_data", o_data, C1);
            chk("bp_hold_valid", 64'(o_out_valid), 64'd1);
            chk("bp_in_ready", 64'(o_in_ready), 64'd0);
        end
        tick();
        i_in_valid = 0;
        i_out_ready = 1;
        tick();
        i_out_ready = 0;
        @(negedge clk);
        chk("bp_valid_fall", 64'(o_out_valid), 64'd0);
        chk("bp_ready_back", 64'(o_in_ready), 64'd1);
        tick();
        i_out_ready = 1;

        // Back-to-back with i_in_valid held high.
        i_key = K1;
        i_data = P1;
        i_mode = 0;
        i_in_valid = 1;
        tick();
        acc1 = cyc;
        i_key = 64'd0;
        i_data = 64'd0;
        wait_valid("b2b_first", ok);
        if (ok) chk("b2b_first", o_data, C1);
        acc2 = -1;
        for (int n = 0; n < 10 && acc2 < 0; n++) begin
            @(negedge clk);
            if (o_in_ready) acc2 = cyc + 1;
        end
        chk("b2b_spacing", 64'(acc2 - acc1), 64'd18);
        tick();
        i_in_valid = 0;
        wait_valid("b2b_second", ok);
        if (ok) chk("b2b_second", o_data, Z1);
        tick();

        // Reset abort during round 7.
        tick();
        i_key = K1;
        i_data = C1;
        i_mode = 1;
        i_in_valid = 1;
        tick();
        i_in_valid = 0;
        repeat (6) tick();
        i_rst_n = 0;
        @(negedge clk);
        chk("abort_valid", 64'(o_out_valid), 64'd0);
        chk("abort_ready", 64'(o_in_ready), 64'd1);
        tick();
        i_rst_n = 1;
        seen = 0;
        repeat (20) begin
            @(negedge clk);
            if (o_out_valid) seen = 1;
        end
        chk("abort_no_output", 64'(seen), 64'd0);
        tick();
        run_block(K1, C1, 1'b1, P1, "after_abort");

        repeat (2) tick();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
